// File: rtl/elevator_scheduler.sv
// elevator_scheduler: three-floor elevator controller with scan (elevator-algorithm) scheduling
module elevator_scheduler #(
    parameter int DOOR_TICKS   = 4,
    parameter int TRAVEL_TICKS = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tick,
    input  logic [2:0] interior_panel,
    input  logic [2:0] exterior_panel,
    output logic [1:0] engine,
    output logic [2:0] doors,
    output logic [1:0] current_floor,
    output logic       direction,
    output logic [2:0] requests,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_OPEN = 2'd1, S_MOVE = 2'd2} state_t;
    state_t     r_state, w_state_n;
    logic [1:0] r_floor, w_floor_n, w_arr_floor;
    logic       r_dir, w_dir_n;
    logic [2:0] r_req, w_clr;
    logic [3:0] r_door, w_door_n, r_trav, w_trav_n;
    logic [1:0] r_engine;
    logic [2:0] r_doors;
    logic       r_busy;
    logic [2:0] w_press, w_here, w_new, w_pend, w_above, w_below, w_arr_mask;
    logic       w_stay, w_hit_here, w_ahead, w_arr_hit, w_eval;

    assign w_press     = interior_panel | exterior_panel;
    assign w_here      = 3'b001 << r_floor;
    assign w_stay      = r_state != S_MOVE;
    assign w_hit_here  = w_stay && |(w_press & w_here);
    assign w_new       = w_press & ~(w_stay ? w_here : 3'b000);
    assign w_pend      = r_req | w_new;
    assign w_above     = 3'b110 << r_floor;
    assign w_below     = ~(w_above | w_here);
    assign w_ahead     = |(w_pend & (r_dir ? w_above : w_below));
    assign w_arr_floor = r_dir ? r_floor + 2'd1 : r_floor - 2'd1;
    assign w_arr_mask  = 3'b001 << w_arr_floor;
    assign w_arr_hit   = |(w_pend & w_arr_mask) || w_arr_floor == (r_dir ? 2'd2 : 2'd0);

    assign engine        = r_engine;
    assign doors         = r_doors;
    assign current_floor = r_floor;
    assign direction     = r_dir;
    assign requests      = r_req;
    assign busy          = r_busy;

    // Next-state: timers advance on tick; IDLE and door expiry share the scan decision
    always_comb begin
        w_state_n = r_state;
        w_floor_n = r_floor;
        w_dir_n   = r_dir;
        w_door_n  = r_door;
        w_trav_n  = r_trav;
        w_clr     = 3'b000;
        w_eval    = 1'b0;
        if (r_state == S_IDLE) begin
            w_eval = 1'b1;
        end else if (r_state == S_OPEN) begin
            if (w_hit_here) begin
                w_door_n = 4'(DOOR_TICKS);
            end else if (tick) begin
                w_door_n = r_door <= 4'd1 ? 4'd0 : r_door - 4'd1;
                w_eval   = r_door <= 4'd1;
            end
        end else if (tick) begin
            if (r_trav <= 4'd1) begin
                w_floor_n = w_arr_floor;
                w_state_n = w_arr_hit ? S_OPEN : S_MOVE;
                w_door_n  = w_arr_hit ? 4'(DOOR_TICKS) : r_door;
                w_trav_n  = w_arr_hit ? 4'd0 : 4'(TRAVEL_TICKS);
                w_clr     = w_arr_hit ? w_arr_mask : 3'b000;
            end else begin
                w_trav_n = r_trav - 4'd1;
            end
        end
        if (w_eval) begin
            if (w_hit_here || |(w_pend & w_here)) begin
                w_state_n = S_OPEN;
                w_door_n  = 4'(DOOR_TICKS);
                w_clr     = w_here;
            end else if (|w_pend) begin
                w_state_n = S_MOVE;
                w_dir_n   = w_ahead ? r_dir : ~r_dir;
                w_trav_n  = 4'(TRAVEL_TICKS);
            end else begin
                w_state_n = S_IDLE;
            end
        end
    end

    // State, request latch and registered outputs; reset overrides everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_floor  <= 2'd0;
            r_dir    <= 1'b1;
            r_req    <= 3'b000;
            r_door   <= 4'd0;
            r_trav   <= 4'd0;
            r_engine <= 2'b00;
            r_doors  <= 3'b000;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_floor  <= w_floor_n;
            r_dir    <= w_dir_n;
            r_req    <= (r_req | w_new) & ~w_clr;
            r_door   <= w_door_n;
            r_trav   <= w_trav_n;
            r_engine <= w_state_n == S_MOVE ? {1'b1, ~w_dir_n} : 2'b00;
            r_doors  <= w_state_n == S_OPEN ? 3'b001 << w_floor_n : 3'b000;
            r_busy   <= w_state_n != S_IDLE;
        end
    end
endmodule
